sar_search_ctrl: RTL and testbench

Successive-approximation search controller that drives the trial operand of an external combinational magnitude comparator and reads back its greater/equal/less flags. It recovers an unknown WIDTH-bit target by binary search, MSB first, and exits early on equality. Its trial output feeds the comparator's b input and the target feeds the comparator's a input. It sits beside the comparator as the sequential initiator of the compare protocol.

---
 rtl/sar_search_ctrl.sv | 112 +++++++++++
 tb/tb_sar_search_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: walks a trial value MSB-first
// against an external comparator and exits early when the comparator reports equality.
module sar_search_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_greater_b,
  input  logic             a_equal_b,
  input  logic             a_lesser_b,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);
  localparam logic [IW-1:0]    IDX_MSB = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bit_cur, bit_nxt;
  logic             flags_ok;

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = err_q;
    bit_cur  = ONE << idx_q;
    bit_nxt  = bit_cur >> 1;
    flags_ok = $onehot({a_greater_b, a_equal_b, a_lesser_b});
    case (state_q)
      IDLE: begin
        if (start) begin
          trial_d  = MSB;
          idx_d    = IDX_MSB;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = CMP;
        end
      end
      CMP: begin
        // Every exit path returns the trial bus to zero and pulses done.
        if (!flags_ok || (a_greater_b && idx_q == '0)) begin
          err_d    = 1'b1;
          result_d = '0;
          trial_d  = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (a_equal_b) begin
          result_d = trial_q;
          trial_d  = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (a_greater_b) begin
          trial_d = trial_q | bit_nxt;
          idx_d   = idx_q - IDX_ONE;
        end else if (idx_q != '0) begin
          trial_d = (trial_q & ~bit_cur) | bit_nxt;
          idx_d   = idx_q - IDX_ONE;
        end else begin
          // Below the LSB trial with every higher bit cleared: target is zero.
          result_d = trial_q & ~ONE;
          trial_d  = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= IDX_MSB;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q == CMP);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: comparator model with fault override, plus a
// bit-by-bit binary-search reference that predicts trials, result and err.
module tb_sar_search_ctrl;
  localparam int W = 3;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic         gt, eq, lt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;

  logic [W-1:0] target = '0;
  int           mode = 0;
  logic         fault_on = 1'b0;

  int checks = 0, errors = 0;

  logic [W-1:0] obs_q[$], exp_q[$];
  int           obs_lat;
  logic         obs_done, obs_err, exp_err;
  logic [W-1:0] obs_res, obs_tend, exp_res;

  always #5 clk = ~clk;

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_greater_b(gt), .a_equal_b(eq), .a_lesser_b(lt),
    .trial(trial), .busy(busy), .done(done), .result(result), .err(err)
  );

  // mode 1: all flags low, 2: gt+lt high, 3: gt only
  always_comb begin
    gt = (target > trial);
    eq = (target == trial);
    lt = (target < trial);
    if (fault_on) begin
      case (mode)
        1: {gt, eq, lt} = 3'b000;
        2: {gt, eq, lt} = 3'b101;
        3: {gt, eq, lt} = 3'b100;
        default: ;
      endcase
    end
  end

  // Binary search over the target: try each bit MSB-first, keep it if the
  // target is at least that large. Faults replace the answer at cycle fcyc.
  function automatic void ref_model(input logic [W-1:0] tgt, input int md, input int fcyc);
    logic [W-1:0] pre, t;
    bit fin;
    exp_q.delete(); exp_res = '0; exp_err = 1'b0; pre = '0; fin = 0;
    for (int b = W - 1; b >= 0 && !fin; b--) begin
      t = pre | (W'(1) << b);
      exp_q.push_back(t);
      if ((md == 1 || md == 2) && exp_q.size() == fcyc) begin exp_err = 1'b1; fin = 1; end
      else if (md != 3 && tgt == t) begin exp_res = t; fin = 1; end
      else if (md == 3 || tgt > t) begin
        pre = t;
        if (b == 0) begin exp_err = 1'b1; fin = 1; end
      end
      else if (b == 0) begin exp_res = pre; fin = 1; end
    end
  endfunction

  function automatic logic [31:0] enc_obs();
    logic [31:0] s;
    s = '0;
    foreach (obs_q[i]) s = (s << (W + 1)) | 32'({1'b1, obs_q[i]});
    return s;
  endfunction

  function automatic logic [31:0] enc_exp();
    logic [31:0] s;
    s = '0;
    foreach (exp_q[i]) s = (s << (W + 1)) | 32'({1'b1, exp_q[i]});
    return s;
  endfunction

  // Drives one search and records what the DUT did; scenarios judge it.
  task automatic run(input logic [W-1:0] tgt, input int md, input int fcyc,
                     input int poke, input bit nowait);
    target = tgt; mode = md; fault_on = 1'b0;
    obs_q.delete(); obs_lat = 0; obs_done = 1'b0; obs_res = '0; obs_err = 1'b0; obs_tend = '0;
    if (!nowait) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4 * W + 4 && !obs_done; k++) begin
      start = 1'b0;
      if (done) begin
        obs_done = 1'b1; obs_res = result; obs_err = err; obs_tend = trial;
      end else begin
        if (busy) begin
          obs_q.push_back(trial);
          obs_lat++;
          fault_on = (md == 3) || ((md == 1 || md == 2) && obs_lat == fcyc);
          start = (obs_lat == poke);
        end
        @(negedge clk);
      end
    end
    fault_on = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({trial, result, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {trial, result, busy, done, err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got %b want 000", {busy, done, err});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] tg[4]  = '{3'd5, 3'd4, 3'd7, 3'd0};
    logic [31:0]  sq[4]  = '{32'hCED, 32'hC, 32'hCEF, 32'hCA9};
    int           lat[4] = '{3, 1, 3, 3};
    for (int i = 0; i < 4; i++) begin
      run(tg[i], 0, 0, 0, 0);
      checks++;
      if (enc_obs() !== sq[i]) begin
        errors++; $display("FAIL dir_trials t=%0d got %h want %h", tg[i], enc_obs(), sq[i]);
      end
      checks++;
      if (obs_done !== 1'b1 || obs_lat != lat[i]) begin
        errors++; $display("FAIL dir_latency t=%0d done=%b got %0d want %0d", tg[i], obs_done, obs_lat, lat[i]);
      end
      checks++;
      if (obs_res !== tg[i] || obs_err !== 1'b0 || obs_tend !== '0) begin
        errors++; $display("FAIL dir_result t=%0d got res=%0d err=%b trial=%0d want res=%0d err=0 trial=0",
                           tg[i], obs_res, obs_err, obs_tend, tg[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] t;
    for (int i = 0; i < 16; i++) begin
      t = W'($urandom_range(0, (1 << W) - 1));
      ref_model(t, 0, 0);
      run(t, 0, 0, 0, 0);
      checks++;
      if (enc_obs() !== enc_exp() || obs_done !== 1'b1) begin
        errors++; $display("FAIL rand_trials t=%0d got %h done=%b want %h", t, enc_obs(), obs_done, enc_exp());
      end
      checks++;
      if (obs_res !== exp_res || obs_err !== exp_err) begin
        errors++; $display("FAIL rand_result t=%0d got %0d/%b want %0d/%b", t, obs_res, obs_err, exp_res, exp_err);
      end
    end
  endtask

  task automatic test_faults();
    logic [W-1:0] t;
    for (int md = 1; md <= 2; md++) begin
      t = W'($urandom_range(0, 6));
      if (t >= 3'd4) t = t + 3'd1;
      ref_model(t, md, 2);
      run(t, md, 2, 0, 0);
      checks++;
      if (enc_obs() !== enc_exp() || obs_done !== 1'b1) begin
        errors++; $display("FAIL fault_trials m=%0d got %h want %h", md, enc_obs(), enc_exp());
      end
      checks++;
      if (obs_err !== 1'b1 || obs_res !== '0 || obs_tend !== '0) begin
        errors++; $display("FAIL fault_resp m=%0d got err=%b res=%0d trial=%0d want err=1 res=0 trial=0",
                           md, obs_err, obs_res, obs_tend);
      end
      ref_model(t, 0, 0);
      run(t, 0, 0, 0, 0);
      checks++;
      if (obs_err !== 1'b0 || obs_res !== exp_res) begin
        errors++; $display("FAIL fault_clear m=%0d got err=%b res=%0d want err=0 res=%0d", md, obs_err, obs_res, exp_res);
      end
    end
  endtask

  task automatic test_gt_at_zero();
    run(W'($urandom_range(0, 7)), 3, 0, 0, 0);
    checks++;
    if (enc_obs() !== 32'hCEF || obs_err !== 1'b1 || obs_res !== '0 || obs_done !== 1'b1) begin
      errors++; $display("FAIL gt_at_zero got seq=%h err=%b res=%0d done=%b want seq=cef err=1 res=0 done=1",
                         enc_obs(), obs_err, obs_res, obs_done);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] t;
    t = W'($urandom_range(5, 7));
    ref_model(t, 0, 0);
    run(t, 0, 0, 1, 0);
    checks++;
    if (enc_obs() !== enc_exp() || obs_res !== exp_res) begin
      errors++; $display("FAIL start_busy t=%0d got %h/%0d want %h/%0d", t, enc_obs(), obs_res, enc_exp(), exp_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] t;
    run(3'd5, 0, 0, 0, 0);
    t = W'($urandom_range(0, 7));
    ref_model(t, 0, 0);
    run(t, 0, 0, 0, 1);
    checks++;
    if (enc_obs() !== enc_exp() || obs_res !== exp_res || obs_done !== 1'b1) begin
      errors++; $display("FAIL back_to_back t=%0d got %h/%0d want %h/%0d", t, enc_obs(), obs_res, enc_exp(), exp_res);
    end
  endtask

  task automatic test_reset_mid_search();
    bit bad;
    target = 3'd5; mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({trial, result, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_mid_async got %b want 0", {trial, result, busy, done, err});
    end
    bad = 0;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || trial !== '0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_mid_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_faults();
    test_gt_at_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
